register_alias_table: RTL
=========================

// Module: register_alias_table
// PURPOSE
//  Speculative RAT: the table side of the Rename<->RAT interface. Rename sends
//  source/dest aregs and new preg aliases; the RAT answers with the current preg
//  aliases. An internal retirement RAT (RRAT) is updated by commit and restores
//  the speculative table on flush. Sits between Rename and Commit.
// PARAMETERS
//  NUM_AREGS     32  architectural registers; areg 0 is hardwired
//  NUM_PREGS     64  physical registers (must be >= NUM_AREGS)
//  RENAME_WIDTH  2   rename/commit slots per cycle
//  NUM_RD        2*RENAME_WIDTH  read ports (two sources per slot)
//  NUM_CKPT      4   checkpoints (only with RAT_CHECKPOINT_EN)
//  AW=$clog2(NUM_AREGS), PW=$clog2(NUM_PREGS), CW=$clog2(NUM_CKPT) (derived)
// PORTS
//  clk               in   1                 clock, rising edge
//  rst_n             in   1                 async reset, active low
//  rd_areg_i         in   NUM_RD x AW       aregs to translate
//  rd_preg_o         out  NUM_RD x PW       current alias of each rd_areg_i
//  wr_en_i           in   RENAME_WIDTH      per-slot rename write enable
//  wr_areg_i         in   RENAME_WIDTH x AW dest areg per slot
//  wr_preg_i         in   RENAME_WIDTH x PW new alias per slot
//  cm_en_i           in   RENAME_WIDTH      per-slot commit enable
//  cm_areg_i         in   RENAME_WIDTH x AW committed dest areg
//  cm_preg_i         in   RENAME_WIDTH x PW committed preg
//  flush_i           in   1                 restore spec table from RRAT
//  ready_o           out  1                 RAT accepts reads/writes this cycle
//  ckpt_take_i       in   1                 [RAT_CHECKPOINT_EN] snapshot table
//  ckpt_take_id_i    in   CW                [RAT_CHECKPOINT_EN] slot to write
//  ckpt_restore_i    in   1                 [RAT_CHECKPOINT_EN] restore snapshot
//  ckpt_restore_id_i in   CW                [RAT_CHECKPOINT_EN] slot to read
// BEHAVIOUR
//  - Reset (async, rst_n=0): spec table and RRAT = identity (areg i -> preg i);
//    FSM=RUN; ready_o=1; checkpoints = identity.
//  - Reads combinational, zero latency; return the table as of cycle start, so
//    same-cycle wr_* is NOT visible (Rename bypasses intra-group deps).
//    rd_areg 0 always returns preg 0.
//  - Writes on the rising edge when wr_en_i[s] && ready_o. Same areg in several
//    slots: highest slot index wins. Writes to areg 0 are dropped.
//  - Commit updates RRAT at the edge; same priority rules; areg 0 dropped.
//    Commits are accepted in every FSM state, independent of ready_o.
//  - FSM RUN -> RECOVER on flush_i: at that edge the spec table <= RRAT
//    next-state (this cycle's commits included); this cycle's wr_* discarded.
//    RECOVER: ready_o=0, wr_en_i ignored, reads return the restored table;
//    -> RUN after one cycle. flush_i in RECOVER re-copies and stays one more cycle.
//  - Priority at an edge: flush > ckpt_restore > rename writes.
//  - No X propagation: out-of-range areg (>= NUM_AREGS) reads return 0 and
//    writes are dropped.
// CONFIGURATION
//  RAT_CHECKPOINT_EN defined: NUM_CKPT snapshot copies.
//    ckpt_take_i saves the table next-state (this cycle's writes included) into
//    slot ckpt_take_id_i.
//    ckpt_restore_i (RUN, no flush) loads the slot into the table in one edge;
//    this cycle's writes are discarded; no RECOVER bubble.
//    Take and restore in the same cycle: restore applies; the take snapshots
//    the restored value.
//  Undefined: ckpt_* ports absent; recovery only via flush_i.
// TESTING
//  T1 reset, read areg 5 and 31 -> preg 5, 31; ready_o=1.
//  T2 wr slot0 areg3->p40 and slot1 areg3->p41 in one cycle; the same-cycle read
//     of areg3 gives p3; next cycle it gives p41.
//  T3 wr areg0->p50; read areg0 -> p0. Read areg 32 (out of range) -> 0.
//  T4 commit areg7->p45; rename areg7->p46; flush_i together with commit
//     areg8->p47 -> next cycle areg7=p45, areg8=p47, ready_o=0 for 1 cycle.
//  T5 (CKPT) take id1 with areg2->p60; then areg2->p61; restore id1 -> areg2=p60.
//  T6 assert rst_n=0 mid-RECOVER -> identity table, ready_o=1 immediately.

Source files
------------

// File: rtl/register_alias_table.sv
// Speculative register alias table with a retirement copy (RRAT) used for flush recovery.
// Optional snapshot checkpoints are compiled in when RAT_CHECKPOINT_EN is defined.
module register_alias_table #(
  parameter int NUM_AREGS    = 32,
  parameter int NUM_PREGS    = 64,
  parameter int RENAME_WIDTH = 2,
  parameter int NUM_RD       = 2 * RENAME_WIDTH,
  parameter int NUM_CKPT     = 4,
  localparam int AW = $clog2(NUM_AREGS),
  localparam int PW = $clog2(NUM_PREGS),
  localparam int CW = (NUM_CKPT > 1) ? $clog2(NUM_CKPT) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [AW-1:0]           rd_areg_i [NUM_RD],
  output logic [PW-1:0]           rd_preg_o [NUM_RD],
  input  logic [RENAME_WIDTH-1:0] wr_en_i,
  input  logic [AW-1:0]           wr_areg_i [RENAME_WIDTH],
  input  logic [PW-1:0]           wr_preg_i [RENAME_WIDTH],
  input  logic [RENAME_WIDTH-1:0] cm_en_i,
  input  logic [AW-1:0]           cm_areg_i [RENAME_WIDTH],
  input  logic [PW-1:0]           cm_preg_i [RENAME_WIDTH],
  input  logic                    flush_i,
  output logic                    ready_o,
`ifdef RAT_CHECKPOINT_EN
  input  logic                    ckpt_take_i,
  input  logic [CW-1:0]           ckpt_take_id_i,
  input  logic                    ckpt_restore_i,
  input  logic [CW-1:0]           ckpt_restore_id_i,
`endif
  output logic                    dbg_state_o
);

  // Handshake: wr_* is consumed at a rising edge only when ready_o is high in
  // that cycle; cm_* is consumed at every edge regardless of ready_o.

  typedef enum logic {ST_RUN = 1'b0, ST_RECOVER = 1'b1} state_t;

  state_t state_q, state_d;

  logic [PW-1:0] spec_q   [NUM_AREGS];
  logic [PW-1:0] rrat_q   [NUM_AREGS];
  logic [PW-1:0] spec_wr  [NUM_AREGS];
  logic [PW-1:0] spec_nxt [NUM_AREGS];
  logic [PW-1:0] rrat_nxt [NUM_AREGS];
  logic          restore_go;

  // Areg 0 is hardwired and out-of-range aregs are never stored.
  function automatic logic areg_ok(input logic [AW-1:0] a);
    return (a != '0) && (int'(a) < NUM_AREGS);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rd_preg_o[i] = '0;
      if (areg_ok(rd_areg_i[i])) rd_preg_o[i] = spec_q[rd_areg_i[i]];
    end
  end

  // Later slots are applied last so the highest slot index wins.
  always_comb begin
    rrat_nxt = rrat_q;
    for (int s = 0; s < RENAME_WIDTH; s++)
      if (cm_en_i[s] && areg_ok(cm_areg_i[s])) rrat_nxt[cm_areg_i[s]] = cm_preg_i[s];
  end

  always_comb begin
    spec_wr = spec_q;
    for (int s = 0; s < RENAME_WIDTH; s++)
      if (wr_en_i[s] && areg_ok(wr_areg_i[s])) spec_wr[wr_areg_i[s]] = wr_preg_i[s];
  end

`ifdef RAT_CHECKPOINT_EN
  logic [PW-1:0] ckpt_q [NUM_CKPT][NUM_AREGS];

  assign restore_go = ckpt_restore_i && (state_q == ST_RUN) && !flush_i;
`else
  assign restore_go = 1'b0;
`endif

  always_comb begin
    spec_nxt = spec_q;
    if (flush_i) begin
      spec_nxt = rrat_nxt;
    end else if (restore_go) begin
`ifdef RAT_CHECKPOINT_EN
      spec_nxt = ckpt_q[ckpt_restore_id_i];
`endif
    end else if (state_q == ST_RUN) begin
      spec_nxt = spec_wr;
    end
  end

  always_comb begin
    state_d     = ST_RUN;
    ready_o     = (state_q == ST_RUN);
    dbg_state_o = state_q;
    if (flush_i) state_d = ST_RECOVER;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_AREGS; i++) begin
        spec_q[i] <= PW'(i);
        rrat_q[i] <= PW'(i);
      end
    end else begin
      spec_q <= spec_nxt;
      rrat_q <= rrat_nxt;
    end
  end

`ifdef RAT_CHECKPOINT_EN
  // A take captures the table next-state, so a simultaneous restore is what gets saved.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CKPT; c++)
        for (int i = 0; i < NUM_AREGS; i++)
          ckpt_q[c][i] <= PW'(i);
    end else if (ckpt_take_i) begin
      ckpt_q[ckpt_take_id_i] <= spec_nxt;
    end
  end
`endif

endmodule
